// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced pushbutton reader with press/release/long-press events
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   btn_in        raw asynchronous button pin
//   btn_level     debounced level, 1 = pressed
//   press_pulse   one-cycle pulse on an accepted press
//   release_pulse one-cycle pulse on an accepted release
//   long_pulse    one-cycle pulse when a hold reaches LONG_PRESS_CYCLES (once per press)
//   press_count   wrapping count of accepted presses
module button_reader #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int CNT_W             = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic              s1_q, s2_q;
  logic              p;
  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Synchronizer flops reset to the released pin value so a button held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= ACTIVE_LOW;
      s2_q <= ACTIVE_LOW;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // Normalized level: 1 = pressed regardless of pin polarity.
  assign p = s2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;
    count_d     = count_q;

    // Hold timer runs in both HELD and RELEASE_WAIT so release bounce does
    // not disturb long-press detection; it saturates at HOLD_LAST.
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (hold_q < HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (p) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          level_d     = 1'b1;
          press_d     = 1'b1;
          count_d     = count_q + 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule
